// File: rtl/pi_gpio_rx_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pi_comm_pkg
// Brief    : Shared types and constants for the Pi GPIO receive path.
// Revision : 1.0 - initial release
// ============================================================================
package pi_comm_pkg;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PAYLOAD = 1'b1
  } rx_state_e;

  localparam logic [1:0] LED_VIEW_LAST   = 2'b00;
  localparam logic [1:0] LED_VIEW_LEVEL  = 2'b01;
  localparam logic [1:0] LED_VIEW_STATUS = 2'b10;
  localparam logic [1:0] LED_VIEW_HEAD   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/pi_gpio_rx_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : pi_gpio_rx_buffer_if
// Brief    : GPIO beat input plus valid/ready drain port of the receive buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface pi_gpio_rx_buffer_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] gpio_pin;
  logic              write_enable;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  modport master (
    output gpio_pin, write_enable, rd_ready,
    input  rd_data, rd_valid
  );

  modport slave (
    input  gpio_pin, write_enable, rd_ready,
    output rd_data, rd_valid
  );
endinterface
`default_nettype wire

// File: rtl/pi_gpio_rx_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pi_rx_fifo
// Brief    : Show-ahead synchronous FIFO with flush; push+pop allowed when full.
// Revision : 1.0 - initial release
// ============================================================================
module pi_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  wire                       pi_clk,
  input  wire                       rst_n,
  input  wire                       flush,
  input  wire                       push,
  input  wire                       pop,
  input  wire  [DATA_W-1:0]         wr_data,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      full,
  output logic                      empty,
  output logic                      push_ok,
  output logic [$clog2(DEPTH):0]    level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              w_pop;
  logic              w_push;

  assign full    = (r_level == LW'(DEPTH));
  assign empty   = (r_level == '0);
  assign w_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = push & (~full | w_pop);
  assign push_ok = w_push & ~flush;
  assign rd_data = r_mem[r_rd_ptr];
  assign level   = r_level;

  always_ff @(posedge pi_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge pi_clk) begin
    if (push_ok) r_mem[r_wr_ptr] <= wr_data;
  end
endmodule
`default_nettype wire

// File: rtl/pi_gpio_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pi_gpio_rx_buffer
// Brief    : Pi GPIO receive front end: length-header deframer, FIFO, LED view.
// Revision : 1.0 - initial release
// ============================================================================
module pi_gpio_rx_buffer
  import pi_comm_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int FRAMED = 1,
  parameter int LED_W  = 6
) (
  input  wire                       pi_clk,
  input  wire                       rst_n,
  input  wire                       clear,
  pi_gpio_rx_buffer_if.slave        bus,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      frame_done,
  output logic                      overflow,
  input  wire  [1:0]                buttons,
  output logic [LED_W-1:0]          LED
);
  rx_state_e         r_state;
  rx_state_e         w_state_nxt;
  logic [DATA_W-1:0] r_remaining;
  logic [DATA_W-1:0] r_last_byte;
  logic              r_frame_done;
  logic              r_overflow;
  logic              w_beat;
  logic              w_payload_beat;
  logic              w_frame_end;
  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;
  logic [DATA_W-1:0] w_view;

  assign w_beat = bus.write_enable;

  always_ff @(posedge pi_clk or negedge rst_n) begin
    if (!rst_n)     r_state <= S_IDLE;
    else if (clear) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (FRAMED != 0) begin
      case (r_state)
        S_IDLE:    if (w_beat && bus.gpio_pin != '0) w_state_nxt = S_PAYLOAD;
        S_PAYLOAD: if (w_frame_end) w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_payload_beat = 1'b0;
    w_frame_end    = 1'b0;
    if (FRAMED == 0) begin
      w_payload_beat = w_beat;
    end else if (r_state == S_PAYLOAD) begin
      w_payload_beat = w_beat;
      w_frame_end    = w_beat && (r_remaining == DATA_W'(1));
    end
  end

  // Dropped beats still decrement, so frame length is honoured on overflow.
  always_ff @(posedge pi_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining  <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_last_byte  <= '0;
    end else if (clear) begin
      r_remaining  <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (FRAMED != 0 && r_state == S_IDLE && w_beat && bus.gpio_pin != '0)
        r_remaining <= bus.gpio_pin;
      else if (r_state == S_PAYLOAD && w_beat)
        r_remaining <= r_remaining - 1'b1;
      r_frame_done <= w_frame_end;
      if (w_payload_beat && w_full && !bus.rd_ready) r_overflow <= 1'b1;
      if (w_push_ok) r_last_byte <= bus.gpio_pin;
    end
  end

  pi_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .pi_clk  (pi_clk),
    .rst_n   (rst_n),
    .flush   (clear),
    .push    (w_payload_beat),
    .pop     (bus.rd_ready),
    .wr_data (bus.gpio_pin),
    .rd_data (bus.rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .push_ok (w_push_ok),
    .level   (level)
  );

  assign bus.rd_valid = ~w_empty;
  assign frame_done   = r_frame_done;
  assign overflow     = r_overflow;

  always_comb begin
    w_view = '0;
    case (buttons)
      LED_VIEW_LAST:   w_view = r_last_byte;
      LED_VIEW_LEVEL:  w_view = DATA_W'(level);
      LED_VIEW_STATUS: w_view = DATA_W'({r_state, r_overflow, w_full, w_empty});
      LED_VIEW_HEAD:   w_view = w_empty ? '0 : bus.rd_data;
      default:         w_view = '0;
    endcase
  end

  assign LED = w_view[LED_W-1:0];
endmodule
`default_nettype wire

// File: tb/tb_pi_gpio_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pi_gpio_rx_buffer
// Brief    : Directed self-checking bench for pi_gpio_rx_buffer (FRAMED=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pi_gpio_rx_buffer;
  logic       pi_clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [1:0] buttons;
  logic [4:0] level;
  logic       frame_done;
  logic       overflow;
  logic [5:0] LED;
  int         n_tests = 0;
  int         n_fail  = 0;

  pi_gpio_rx_buffer_if #(.DATA_W(8)) bus ();

  pi_gpio_rx_buffer #(
    .DATA_W (8),
    .DEPTH  (16),
    .FRAMED (1),
    .LED_W  (6)
  ) dut (
    .pi_clk     (pi_clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bus        (bus),
    .level      (level),
    .frame_done (frame_done),
    .overflow   (overflow),
    .buttons    (buttons),
    .LED        (LED)
  );

  always #5 pi_clk = ~pi_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic beat(input logic [7:0] w);
    bus.gpio_pin     = w;
    bus.write_enable = 1'b1;
    @(negedge pi_clk);
    bus.write_enable = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.rd_data), 32'(exp));
    bus.rd_ready = 1'b1;
    @(negedge pi_clk);
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; buttons = 2'b00;
    bus.gpio_pin = '0; bus.write_enable = 1'b0; bus.rd_ready = 1'b0;
    repeat (2) @(negedge pi_clk);
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_fdone", 32'(frame_done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_led", 32'(LED), 32'd0);
    rst_n = 1'b1;
    @(negedge pi_clk);

    // 1: reset mid-frame, then a clean 2-byte frame
    beat(8'h03); beat(8'h11);
    buttons = 2'b10;
    #1 check("t1_mid_status", 32'(LED), 32'h8);
    buttons = 2'b00;
    rst_n = 1'b0;
    #1;
    check("t1_rst_level", 32'(level), 32'd0);
    check("t1_rst_valid", 32'(bus.rd_valid), 32'd0);
    check("t1_rst_led", 32'(LED), 32'd0);
    @(negedge pi_clk);
    rst_n = 1'b1;
    @(negedge pi_clk);
    beat(8'h02); beat(8'hB1);
    check("t1_fd_early", 32'(frame_done), 32'd0);
    beat(8'hB2);
    check("t1_fd", 32'(frame_done), 32'd1);
    check("t1_level", 32'(level), 32'd2);
    pop_chk("t1_pop0", 8'hB1);
    check("t1_fd_off", 32'(frame_done), 32'd0);
    pop_chk("t1_pop1", 8'hB2);
    check("t1_empty", 32'(bus.rd_valid), 32'd0);

    // 2: header 3 + three payload bytes, no drain
    beat(8'h03); beat(8'hA1); beat(8'hA2);
    check("t2_fd_early", 32'(frame_done), 32'd0);
    beat(8'hA3);
    check("t2_fd", 32'(frame_done), 32'd1);
    check("t2_level", 32'(level), 32'd3);
    check("t2_head", 32'(bus.rd_data), 32'hA1);
    check("t2_led_last", 32'(LED), 32'h23);
    buttons = 2'b01;
    #1 check("t2_led_level", 32'(LED), 32'd3);
    buttons = 2'b11;
    #1 check("t2_led_head", 32'(LED), 32'h21);
    buttons = 2'b00;
    @(negedge pi_clk);
    check("t2_fd_off", 32'(frame_done), 32'd0);
    for (int i = 0; i < 3; i++) pop_chk("t2_drain", 8'(8'hA1 + i));

    // 5: empty frame then a 2-byte frame
    beat(8'h00);
    check("t5_lvl0", 32'(level), 32'd0);
    check("t5_fd0", 32'(frame_done), 32'd0);
    buttons = 2'b10;
    #1 check("t5_idle", 32'(LED), 32'h1);
    buttons = 2'b00;
    beat(8'h02); beat(8'h55); beat(8'h66);
    check("t5_fd", 32'(frame_done), 32'd1);
    check("t5_level", 32'(level), 32'd2);
    pop_chk("t5_pop0", 8'h55);
    pop_chk("t5_pop1", 8'h66);

    // 3: 18-byte frame into 16-entry FIFO
    beat(8'd18);
    for (int i = 0; i < 18; i++) beat(8'(8'hC0 + i));
    check("t3_level", 32'(level), 32'd16);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_fd", 32'(frame_done), 32'd1);
    check("t3_head", 32'(bus.rd_data), 32'hC0);
    buttons = 2'b10;
    #1 check("t3_status", 32'(LED), 32'h6);
    buttons = 2'b00;

    // 4: full + push + pop in one cycle
    beat(8'h01);
    bus.gpio_pin = 8'hEE; bus.write_enable = 1'b1; bus.rd_ready = 1'b1;
    @(negedge pi_clk);
    bus.write_enable = 1'b0; bus.rd_ready = 1'b0;
    check("t4_level", 32'(level), 32'd16);
    check("t4_head", 32'(bus.rd_data), 32'hC1);
    for (int i = 0; i < 15; i++) pop_chk("t4_drain", 8'(8'hC1 + i));
    pop_chk("t4_tail", 8'hEE);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);

    // 6: clear with concurrent beat while overflow set
    beat(8'h05); beat(8'h42);
    bus.gpio_pin = 8'h77; bus.write_enable = 1'b1; clear = 1'b1;
    @(negedge pi_clk);
    bus.write_enable = 1'b0; clear = 1'b0;
    check("t6_level", 32'(level), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    check("t6_valid", 32'(bus.rd_valid), 32'd0);
    buttons = 2'b10;
    #1 check("t6_idle", 32'(LED), 32'h1);
    beat(8'h01);
    check("t6_hdr", 32'(LED), 32'h9);
    beat(8'h3C);
    check("t6_fd", 32'(frame_done), 32'd1);
    check("t6_data", 32'(bus.rd_data), 32'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
